// File: rtl/riscv_csr_file.sv
// Machine-mode CSR file: Zicsr read-modify-write ops, ECALL/MRET trap
// handling, 64-bit mcycle/minstret counters and illegal-access detection.
module riscv_csr_file #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] HART_ID     = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] pc,
  input  logic            ecall,
  input  logic            mret,
  input  logic            instret_inc,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic            trap_redirect,
  output logic [XLEN-1:0] trap_target
);

  localparam logic [11:0] CsrMstatus   = 12'h300;
  localparam logic [11:0] CsrMtvec     = 12'h305;
  localparam logic [11:0] CsrMscratch  = 12'h340;
  localparam logic [11:0] CsrMepc      = 12'h341;
  localparam logic [11:0] CsrMcause    = 12'h342;
  localparam logic [11:0] CsrMcycle    = 12'hB00;
  localparam logic [11:0] CsrMinstret  = 12'hB02;
  localparam logic [11:0] CsrMcycleh   = 12'hB80;
  localparam logic [11:0] CsrMinstreth = 12'hB82;
  localparam logic [11:0] CsrMhartid   = 12'hF14;

  localparam logic [1:0] OpNone = 2'b00;
  localparam logic [1:0] OpRw   = 2'b01;
  localparam logic [1:0] OpRs   = 2'b10;
  localparam logic [1:0] OpRc   = 2'b11;

  // mtvec and mepc keep bits [1:0] at zero by masking on every write.
  localparam logic [XLEN-1:0] LowMask    = ~XLEN'(3);
  localparam logic [XLEN-1:0] CauseEcall = XLEN'(11);
  localparam bit              HasHigh    = (XLEN == 32);

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [63:0]     mcycle_q, mcycle_d;
  logic [63:0]     minstret_q, minstret_d;

  logic [XLEN-1:0] old_val;
  logic            addr_valid;
  logic [XLEN-1:0] wval;
  logic [63:0]     wval64;
  logic            write_intent;
  logic            csr_active;
  logic            read_only_hit;
  logic            illegal;
  logic            csr_we;

  // Address decode and pre-write read value of the addressed CSR.
  always_comb begin
    old_val    = '0;
    addr_valid = 1'b1;
    case (csr_addr)
      CsrMstatus: begin
        old_val[3] = mie_q;
        old_val[7] = mpie_q;
      end
      CsrMtvec:    old_val = mtvec_q;
      CsrMscratch: old_val = mscratch_q;
      CsrMepc:     old_val = mepc_q;
      CsrMcause:   old_val = mcause_q;
      CsrMcycle:   old_val = mcycle_q[XLEN-1:0];
      CsrMinstret: old_val = minstret_q[XLEN-1:0];
      CsrMcycleh: begin
        if (HasHigh) old_val = XLEN'(mcycle_q[63:32]);
        else         addr_valid = 1'b0;
      end
      CsrMinstreth: begin
        if (HasHigh) old_val = XLEN'(minstret_q[63:32]);
        else         addr_valid = 1'b0;
      end
      CsrMhartid: old_val = HART_ID;
      default:    addr_valid = 1'b0;
    endcase
  end

  // Zicsr write value and legality; ecall/mret suppress any CSR op.
  always_comb begin
    case (csr_op)
      OpRs:    wval = old_val | csr_wdata;
      OpRc:    wval = old_val & ~csr_wdata;
      default: wval = csr_wdata;
    endcase
    wval64        = 64'(wval);
    csr_active    = csr_en & (csr_op != OpNone) & ~ecall & ~mret & ~rst;
    write_intent  = (csr_op == OpRw) | (csr_wdata != '0);
    read_only_hit = (csr_addr[11:10] == 2'b11) & write_intent;
    illegal       = csr_active & (~addr_valid | read_only_hit);
    csr_we        = csr_active & write_intent & ~illegal;
  end

  // Next-state: trap entry/return first, then CSR writes, else counters tick.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = instret_inc ? (minstret_q + 64'd1) : minstret_q;
    if (ecall) begin
      mepc_d   = pc & LowMask;
      mcause_d = CauseEcall;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        CsrMstatus: begin
          mie_d  = wval[3];
          mpie_d = wval[7];
        end
        CsrMtvec:    mtvec_d    = wval & LowMask;
        CsrMscratch: mscratch_d = wval;
        CsrMepc:     mepc_d     = wval & LowMask;
        CsrMcause:   mcause_d   = wval;
        // A write to either half replaces the increment for the whole counter.
        CsrMcycle: begin
          if (HasHigh) mcycle_d = {mcycle_q[63:32], wval64[31:0]};
          else         mcycle_d = wval64;
        end
        CsrMinstret: begin
          if (HasHigh) minstret_d = {minstret_q[63:32], wval64[31:0]};
          else         minstret_d = wval64;
        end
        CsrMcycleh:   mcycle_d   = {wval64[31:0], mcycle_q[31:0]};
        CsrMinstreth: minstret_d = {wval64[31:0], minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET & LowMask;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  // Combinational outputs, all forced quiet during reset.
  always_comb begin
    csr_illegal   = illegal;
    csr_rdata     = (rst | ~addr_valid | illegal) ? '0 : old_val;
    trap_redirect = ~rst & (ecall | mret);
    trap_target   = '0;
    if (!rst) begin
      if (ecall)     trap_target = mtvec_q;
      else if (mret) trap_target = mepc_q;
    end
  end

endmodule

// File: tb/tb_riscv_csr_file.sv
// Directed self-checking bench for riscv_csr_file (XLEN=32).
module tb_riscv_csr_file;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] HartId = 32'd5;
  localparam logic [31:0] MtvecRst = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] pc;
  logic        ecall;
  logic        mret;
  logic        instret_inc;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_redirect;
  logic [31:0] trap_target;

  int checks = 0;
  int passed = 0;

  riscv_csr_file #(
    .XLEN       (XLEN),
    .HART_ID    (HartId),
    .MTVEC_RESET(MtvecRst)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .csr_en       (csr_en),
    .csr_op       (csr_op),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .pc           (pc),
    .ecall        (ecall),
    .mret         (mret),
    .instret_inc  (instret_inc),
    .csr_rdata    (csr_rdata),
    .csr_illegal  (csr_illegal),
    .trap_redirect(trap_redirect),
    .trap_target  (trap_target)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_en = 1'b0; csr_op = 2'b00; csr_addr = 12'h000; csr_wdata = '0;
    ecall = 1'b0; mret = 1'b0; instret_inc = 1'b0; pc = '0;
    #1;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    csr_en = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    csr(2'b01, 12'h305, 32'h1234_5678);
    ecall = 1'b1;
    #1;
    checks++;
    if (csr_rdata !== 32'h0 || trap_redirect !== 1'b0 || trap_target !== 32'h0)
      $display("FAIL rst_quiet: rdata=%h redirect=%b target=%h required 0/0/0",
               csr_rdata, trap_redirect, trap_target);
    else passed++;
    tick();
    idle();
    rst = 1'b0;
    csr(2'b10, 12'h305, 32'h0);
    checks++;
    if (csr_rdata !== MtvecRst) $display("FAIL rst_mtvec: got %h required %h", csr_rdata, MtvecRst);
    else passed++;
    csr(2'b10, 12'h300, 32'h0);
    checks++;
    if (csr_rdata !== 32'h0) $display("FAIL rst_mstatus: got %h required 0", csr_rdata);
    else passed++;
    csr(2'b10, 12'hB00, 32'h0);
    checks++;
    if (csr_rdata !== 32'h0) $display("FAIL rst_mcycle: got %h required 0", csr_rdata);
    else passed++;
    idle();
    for (int i = 0; i < 10; i++) tick();
    csr(2'b10, 12'hB00, 32'h0);
    checks++;
    if (csr_rdata !== 32'd10) $display("FAIL mcycle_10: got %0d required 10", csr_rdata);
    else passed++;
    tick();
    idle();
  endtask

  task automatic test_rw_rs_rc();
    csr(2'b01, 12'h340, 32'hDEAD_BEEF);
    checks++;
    if (csr_rdata !== 32'h0) $display("FAIL rw_old: got %h required 0", csr_rdata);
    else passed++;
    tick();
    csr(2'b10, 12'h340, 32'h0000_FFFF);
    checks++;
    if (csr_rdata !== 32'hDEAD_BEEF) $display("FAIL rw_new: got %h required DEADBEEF", csr_rdata);
    else passed++;
    tick();
    csr(2'b11, 12'h340, 32'hFF00_0000);
    checks++;
    if (csr_rdata !== 32'hDEAD_FFFF) $display("FAIL rs_val: got %h required DEADFFFF", csr_rdata);
    else passed++;
    tick();
    csr(2'b10, 12'h340, 32'h0);
    checks++;
    if (csr_rdata !== 32'h00AD_FFFF) $display("FAIL rc_val: got %h required 00ADFFFF", csr_rdata);
    else passed++;
    tick();
    idle();
  endtask

  task automatic test_trap();
    csr(2'b01, 12'h305, 32'h8000_1003);
    tick();
    csr(2'b10, 12'h300, 32'h0000_0008);
    tick();
    csr(2'b10, 12'h305, 32'h0);
    checks++;
    if (csr_rdata !== 32'h8000_1000) $display("FAIL mtvec_mask: got %h required 80001000", csr_rdata);
    else passed++;
    idle();
    ecall = 1'b1; pc = 32'h0000_0100;
    #1;
    checks++;
    if (trap_redirect !== 1'b1 || trap_target !== 32'h8000_1000)
      $display("FAIL ecall_target: redirect=%b target=%h required 1/80001000",
               trap_redirect, trap_target);
    else passed++;
    tick();
    idle();
    csr(2'b10, 12'h341, 32'h0);
    checks++;
    if (csr_rdata !== 32'h100) $display("FAIL ecall_mepc: got %h required 100", csr_rdata);
    else passed++;
    csr(2'b10, 12'h342, 32'h0);
    checks++;
    if (csr_rdata !== 32'd11) $display("FAIL ecall_mcause: got %0d required 11", csr_rdata);
    else passed++;
    csr(2'b10, 12'h300, 32'h0);
    checks++;
    if (csr_rdata !== 32'h80) $display("FAIL ecall_mstatus: got %h required 80", csr_rdata);
    else passed++;
    idle();
    mret = 1'b1;
    #1;
    checks++;
    if (trap_redirect !== 1'b1 || trap_target !== 32'h100)
      $display("FAIL mret_target: redirect=%b target=%h required 1/100", trap_redirect, trap_target);
    else passed++;
    tick();
    idle();
    csr(2'b10, 12'h300, 32'h0);
    checks++;
    if (csr_rdata !== 32'h88) $display("FAIL mret_mstatus: got %h required 88", csr_rdata);
    else passed++;
    tick();
    idle();
  endtask

  task automatic test_illegal();
    csr(2'b01, 12'hF14, 32'h1);
    checks++;
    if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0)
      $display("FAIL hartid_rw: illegal=%b rdata=%h required 1/0", csr_illegal, csr_rdata);
    else passed++;
    tick();
    csr(2'b10, 12'hF14, 32'h0);
    checks++;
    if (csr_illegal !== 1'b0 || csr_rdata !== HartId)
      $display("FAIL hartid_rd: illegal=%b rdata=%h required 0/%h", csr_illegal, csr_rdata, HartId);
    else passed++;
    csr(2'b10, 12'h7C0, 32'h0);
    checks++;
    if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0)
      $display("FAIL unimpl: illegal=%b rdata=%h required 1/0", csr_illegal, csr_rdata);
    else passed++;
    csr(2'b00, 12'h7C0, 32'h0);
    checks++;
    if (csr_illegal !== 1'b0) $display("FAIL op_none: illegal=%b required 0", csr_illegal);
    else passed++;
    // Illegal write to an unimplemented address must leave mscratch alone.
    csr(2'b01, 12'h7C0, 32'h5555_5555);
    tick();
    csr(2'b10, 12'h340, 32'h0);
    checks++;
    if (csr_rdata !== 32'h00AD_FFFF) $display("FAIL illegal_nochg: got %h required 00ADFFFF", csr_rdata);
    else passed++;
    tick();
    idle();
  endtask

  task automatic test_counters();
    csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    tick();
    csr(2'b10, 12'hB00, 32'h0);
    checks++;
    if (csr_rdata !== 32'hFFFF_FFFF) $display("FAIL mcycle_wr: got %h required FFFFFFFF", csr_rdata);
    else passed++;
    tick();
    csr(2'b10, 12'hB00, 32'h0);
    checks++;
    if (csr_rdata !== 32'h0) $display("FAIL mcycle_wrap: got %h required 0", csr_rdata);
    else passed++;
    tick();
    csr(2'b10, 12'hB80, 32'h0);
    checks++;
    if (csr_rdata !== 32'h1) $display("FAIL mcycleh_carry: got %h required 1", csr_rdata);
    else passed++;
    tick();
    csr(2'b01, 12'hB02, 32'h0000_1234);
    instret_inc = 1'b1;
    tick();
    idle();
    csr(2'b10, 12'hB02, 32'h0);
    instret_inc = 1'b1;
    #1;
    checks++;
    if (csr_rdata !== 32'h1234) $display("FAIL minstret_wr: got %h required 1234", csr_rdata);
    else passed++;
    tick();
    idle();
    csr(2'b10, 12'hB02, 32'h0);
    checks++;
    if (csr_rdata !== 32'h1235) $display("FAIL minstret_inc: got %h required 1235", csr_rdata);
    else passed++;
    csr(2'b10, 12'hB82, 32'h0);
    checks++;
    if (csr_rdata !== 32'h0) $display("FAIL minstreth: got %h required 0", csr_rdata);
    else passed++;
    tick();
    idle();
  endtask

  task automatic test_priority();
    csr(2'b01, 12'h340, 32'h1111_1111);
    ecall = 1'b1; pc = 32'h0000_0200;
    #1;
    checks++;
    if (csr_illegal !== 1'b0 || trap_redirect !== 1'b1 || trap_target !== 32'h8000_1000)
      $display("FAIL ecall_prio: illegal=%b redirect=%b target=%h required 0/1/80001000",
               csr_illegal, trap_redirect, trap_target);
    else passed++;
    tick();
    idle();
    csr(2'b10, 12'h340, 32'h0);
    checks++;
    if (csr_rdata !== 32'h00AD_FFFF) $display("FAIL ecall_supp: got %h required 00ADFFFF", csr_rdata);
    else passed++;
    idle();
    csr(2'b01, 12'h7C0, 32'h1);
    mret = 1'b1;
    #1;
    checks++;
    if (csr_illegal !== 1'b0 || trap_target !== 32'h200)
      $display("FAIL mret_prio: illegal=%b target=%h required 0/200", csr_illegal, trap_target);
    else passed++;
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    ecall = 1'b1; pc = 32'h0000_0300;
    #1;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mret = 1'b1;
    #1;
    checks++;
    if (trap_redirect !== 1'b1 || trap_target !== 32'h0)
      $display("FAIL rst_mret: redirect=%b target=%h required 1/0", trap_redirect, trap_target);
    else passed++;
    idle();
    csr(2'b10, 12'h305, 32'h0);
    checks++;
    if (csr_rdata !== MtvecRst) $display("FAIL rst_mid_mtvec: got %h required %h", csr_rdata, MtvecRst);
    else passed++;
    tick();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_rw_rs_rc();
    test_trap();
    test_illegal();
    test_counters();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
